// File: rtl/conversor_binario_bcd_pkg.sv
// Shared constants for the binary-to-BCD converter.
// State encoding, digit correction constant and the digit-count helper.
package conversor_binario_bcd_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] BCD_TRES = 4'd3;

    // Decimal digits needed to show the largest N-bit unsigned value.
    function automatic int min_digitos(input int n);
        longint unsigned v;
        int d;
        if (n >= 64) v = '1;
        else v = (64'd1 << n) - 64'd1;
        d = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            d++;
        end
        return d;
    endfunction

endpackage

// File: rtl/conversor_binario_bcd_if.sv
// Handshake bundle between the ALU result register,
// the converter and the 7-segment decoders.
interface conversor_binario_bcd_if #(
    parameter int N_BITS   = 8,
    parameter int N_DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [N_BITS-1:0]     in_dado;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*N_DIGITS-1:0] out_bcd;
    logic                  out_sinal;

    modport master (
        output in_valid, in_dado, out_ready,
        input  in_ready, out_valid, out_bcd, out_sinal
    );

    modport slave (
        input  in_valid, in_dado, out_ready,
        output in_ready, out_valid, out_bcd, out_sinal
    );
endinterface

// File: rtl/conversor_binario_bcd_corretor.sv
// Per-digit double-dabble correction: adds 3 when the digit is >= 5,
// built from the 4-bit adder and 2:1 mux library cells.
module somador4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] s
);
    assign s = a + b;
endmodule

module multiplexador2x1 #(
    parameter int W = 4
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = sel ? b : a;
endmodule

module corretor_digito_bcd
    import conversor_binario_bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] y
);
    logic [3:0] soma;
    logic       ge5;

    assign ge5 = (d >= 4'd5);

    somador4x4 u_soma (
        .a (d),
        .b (BCD_TRES),
        .s (soma)
    );

    multiplexador2x1 #(.W(4)) u_mux (
        .sel (ge5),
        .a   (d),
        .b   (soma),
        .y   (y)
    );
endmodule

// File: rtl/conversor_binario_bcd.sv
// Sequential binary-to-BCD converter, one double-dabble iteration per clock,
// with optional two's-complement input reported as sign + magnitude.
module conversor_binario_bcd
    import conversor_binario_bcd_pkg::*;
#(
    parameter int N_BITS   = 8,
    parameter int N_DIGITS = 3,
    parameter int SIGNED   = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    conversor_binario_bcd_if.slave bus
);
    localparam int CW = $clog2(N_BITS + 1);
    localparam int BW = 4 * N_DIGITS;
    localparam logic [CW-1:0] CONT_INI = CW'(N_BITS);
    localparam logic [CW-1:0] CONT_UM = CW'(1);
    localparam logic [N_BITS-1:0] UM = N_BITS'(1);

    if (N_BITS < 2) begin : g_erro_bits
        $error("conversor_binario_bcd: N_BITS must be >= 2");
    end
    if (N_DIGITS < min_digitos(N_BITS)) begin : g_erro_digitos
        $error("conversor_binario_bcd: N_DIGITS too small for N_BITS");
    end

    logic [1:0]        estado;
    logic [CW-1:0]     cont;
    logic [N_BITS-1:0] desl;
    logic [BW-1:0]     bcd;
    logic [BW-1:0]     bcd_corr;
    logic [BW-1:0]     bcd_nx;
    logic              sinal;
    logic [BW-1:0]     res_bcd;
    logic              res_sinal;
    logic [N_BITS-1:0] mag;
    logic              sinal_in;

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_dig
        corretor_digito_bcd u_corr (
            .d (bcd[4*i +: 4]),
            .y (bcd_corr[4*i +: 4])
        );
    end

    assign bcd_nx = {bcd_corr[BW-2:0], desl[N_BITS-1]};

    // Most-negative input negates to itself, which reads correctly as unsigned.
    assign sinal_in = (SIGNED != 0) ? bus.in_dado[N_BITS-1] : 1'b0;
    assign mag = sinal_in ? (~bus.in_dado + UM) : bus.in_dado;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado    <= IDLE;
            cont      <= '0;
            desl      <= '0;
            bcd       <= '0;
            sinal     <= 1'b0;
            res_bcd   <= '0;
            res_sinal <= 1'b0;
        end else begin
            case (estado)
                IDLE: begin
                    if (bus.in_valid) begin
                        desl   <= mag;
                        bcd    <= '0;
                        sinal  <= sinal_in;
                        cont   <= CONT_INI;
                        estado <= CONV;
                    end
                end
                CONV: begin
                    bcd  <= bcd_nx;
                    desl <= desl << 1;
                    cont <= cont - CONT_UM;
                    if (cont == CONT_UM) begin
                        res_bcd   <= bcd_nx;
                        res_sinal <= sinal;
                        estado    <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) estado <= IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (estado == IDLE);
    assign bus.out_valid = (estado == DONE);
    assign bus.out_bcd   = res_bcd;
    assign bus.out_sinal = res_sinal;
endmodule

// File: tb/tb_conversor_binario_bcd.sv
// Directed + random bench for the binary-to-BCD converter
// across unsigned 8-bit, signed 8-bit and unsigned 16-bit builds.
module tb_conversor_binario_bcd;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    conversor_binario_bcd_if #(.N_BITS(8), .N_DIGITS(3)) if0 ();
    conversor_binario_bcd_if #(.N_BITS(8), .N_DIGITS(3)) if1 ();
    conversor_binario_bcd_if #(.N_BITS(16), .N_DIGITS(5)) if2 ();

    conversor_binario_bcd #(.N_BITS(8), .N_DIGITS(3), .SIGNED(0)) u0 (
        .clk (clk), .rst_n (rst_n), .bus (if0)
    );
    conversor_binario_bcd #(.N_BITS(8), .N_DIGITS(3), .SIGNED(1)) u1 (
        .clk (clk), .rst_n (rst_n), .bus (if1)
    );
    conversor_binario_bcd #(.N_BITS(16), .N_DIGITS(5), .SIGNED(0)) u2 (
        .clk (clk), .rst_n (rst_n), .bus (if2)
    );

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    logic [19:0] rb;
    logic rs;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_bcd(input longint unsigned v, input int nd);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go0(input logic [7:0] d);
        int t;
        t = 0;
        if0.in_dado = d;
        if0.in_valid = 1'b1;
        while (!if0.in_ready && t < 40) begin @(negedge clk); t++; end
        @(posedge clk);
        @(negedge clk);
        if0.in_valid = 1'b0;
        lat = 0;
        while (!if0.out_valid && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        rb = 20'(if0.out_bcd);
        rs = if0.out_sinal;
    endtask

    task automatic go1(input logic [7:0] d);
        int t;
        t = 0;
        if1.in_dado = d;
        if1.in_valid = 1'b1;
        while (!if1.in_ready && t < 40) begin @(negedge clk); t++; end
        @(posedge clk);
        @(negedge clk);
        if1.in_valid = 1'b0;
        lat = 0;
        while (!if1.out_valid && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        rb = 20'(if1.out_bcd);
        rs = if1.out_sinal;
    endtask

    task automatic go2(input logic [15:0] d);
        int t;
        t = 0;
        if2.in_dado = d;
        if2.in_valid = 1'b1;
        while (!if2.in_ready && t < 40) begin @(negedge clk); t++; end
        @(posedge clk);
        @(negedge clk);
        if2.in_valid = 1'b0;
        lat = 0;
        while (!if2.out_valid && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        rb = if2.out_bcd;
        rs = if2.out_sinal;
    endtask

    initial begin
        logic [7:0] d8;
        logic [15:0] d16;
        int mg;
        int t;

        rst_n = 1'b0;
        if0.in_valid = 1'b0; if0.in_dado = '0; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.in_dado = '0; if1.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.in_dado = '0; if2.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(if0.in_ready), 1);
        chk("rst_out_valid", 32'(if0.out_valid), 0);
        chk("rst_out_bcd", 32'(if0.out_bcd), 0);
        chk("rst_sinal", 32'(if1.out_sinal), 0);

        go0(8'd255);
        chk("lat_255", lat, 8);
        chk("bcd_255", 32'(rb), 32'h255);
        chk("sinal_255", 32'(rs), 0);
        go0(8'd0);
        chk("bcd_0", 32'(rb), 32'h000);

        go1(8'h80);
        chk("s_80_sinal", 32'(rs), 1);
        chk("s_80_bcd", 32'(rb), 32'h128);
        go1(8'hFF);
        chk("s_ff_sinal", 32'(rs), 1);
        chk("s_ff_bcd", 32'(rb), 32'h001);
        go1(8'h7F);
        chk("s_7f_sinal", 32'(rs), 0);
        chk("s_7f_bcd", 32'(rb), 32'h127);

        // backpressure
        if0.out_ready = 1'b0;
        go0(8'd99);
        chk("bp_bcd", 32'(rb), 32'h099);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_%0d", i),
                {18'd0, if0.out_valid, if0.in_ready, if0.out_bcd}, {18'd0, 2'b10, 12'h099});
        end
        if0.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {30'd0, if0.out_valid, if0.in_ready}, 32'b01);

        // in_valid pulse while busy must be ignored
        if0.in_dado = 8'd17;
        if0.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if0.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if0.in_dado = 8'd42;
        if0.in_valid = 1'b1;
        @(negedge clk);
        if0.in_valid = 1'b0;
        t = 0;
        while (!if0.out_valid && t < 40) begin @(negedge clk); t++; end
        chk("busy_first", 32'(if0.out_bcd), 32'h017);
        repeat (3) @(negedge clk);
        chk("busy_idle", {30'd0, if0.out_valid, if0.in_ready}, 32'b01);
        go0(8'd42);
        chk("busy_42", 32'(rb), 32'h042);

        // reset in the middle of a conversion
        if0.in_dado = 8'd123;
        if0.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if0.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(if0.out_valid), 0);
        chk("mid_rst_bcd", 32'(if0.out_bcd), 0);
        chk("mid_rst_ready", 32'(if0.in_ready), 1);
        t = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if0.out_valid) t++;
        end
        chk("mid_rst_no_result", t, 0);
        go0(8'd200);
        chk("mid_rst_200", 32'(rb), 32'h200);

        go2(16'd65535);
        chk("w16_lat", lat, 16);
        chk("w16_bcd", 32'(rb), 32'h65535);

        for (int i = 0; i < 20; i++) begin
            d8 = 8'($urandom);
            go0(d8);
            chk($sformatf("rnd_u8_%0d", d8), 32'(rb), ref_bcd(64'(d8), 3));
        end
        for (int i = 0; i < 20; i++) begin
            d8 = 8'($urandom);
            mg = (d8 >= 8'd128) ? 256 - int'(d8) : int'(d8);
            go1(d8);
            chk($sformatf("rnd_s8_bcd_%0h", d8), 32'(rb), ref_bcd(64'(mg), 3));
            chk($sformatf("rnd_s8_sig_%0h", d8), 32'(rs), (d8 >= 8'd128) ? 1 : 0);
        end
        for (int i = 0; i < 10; i++) begin
            d16 = 16'($urandom);
            go2(d16);
            chk($sformatf("rnd_u16_%0d", d16), 32'(rb), ref_bcd(64'(d16), 5));
            chk($sformatf("rnd_u16_lat_%0d", d16), lat, 16);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
